conv_window_ctrl: RTL and testbench



---
 rtl/conv_window_ctrl.sv | 115 +++++++++++
 tb/tb_conv_window_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_ctrl.sv
`timescale 1ns/1ps
// conv_window_ctrl
//   Control/timing core of the convolution engine. Counts a raster stream of
//   IMG_W x IMG_H pixels, flags each pixel that completes a KxK window at the
//   configured stride, and presents that event LAT clock edges later so it
//   lines up with the MAC array result.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   one pixel accepted per rising edge while high
//   out_valid   out  one convolution result valid this cycle
//   out_row     out  output-map row of the current result
//   out_col     out  output-map column of the current result
//   frame_done  out  one-cycle pulse together with the frame's last result
module conv_window_ctrl #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int LAT    = 2,
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1,
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          out_valid,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          frame_done
);

  // Input position of the final window of a frame. With a stride that does
  // not divide (IMG-K), the wrapped pixel is not a window, so the end-of-frame
  // marker has to ride on the last real window instead.
  localparam int LAST_R = (K - 1) + ((IMG_H - K) / STRIDE) * STRIDE;
  localparam int LAST_C = (K - 1) + ((IMG_W - K) / STRIDE) * STRIDE;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  int            rel_r, rel_c;
  logic          win_d, last_d;
  logic [RW-1:0] orow_d;
  logic [CW-1:0] ocol_d;

  // Stage 0 captures the window event at the accepting edge; stages 1..LAT
  // delay it so the result appears LAT edges after the accept.
  logic          vld_q  [LAT+1];
  logic          last_q [LAT+1];
  logic [RW-1:0] orow_q [LAT+1];
  logic [CW-1:0] ocol_q [LAT+1];

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_valid) begin
      if (col_q == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_comb begin
    rel_r  = int'(row_q) - (K - 1);
    rel_c  = int'(col_q) - (K - 1);
    win_d  = in_valid && (rel_r >= 0) && (rel_c >= 0) &&
             ((rel_r % STRIDE) == 0) && ((rel_c % STRIDE) == 0);
    orow_d = '0;
    ocol_d = '0;
    if (win_d) begin
      orow_d = RW'(rel_r / STRIDE);
      ocol_d = CW'(rel_c / STRIDE);
    end
    last_d = win_d && (row_q == RW'(LAST_R)) && (col_q == CW'(LAST_C));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      for (int i = 0; i <= LAT; i++) begin
        vld_q[i]  <= 1'b0;
        last_q[i] <= 1'b0;
        orow_q[i] <= '0;
        ocol_q[i] <= '0;
      end
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      // stage 0: window event at the accepting edge
      vld_q[0]  <= win_d;
      last_q[0] <= last_d;
      orow_q[0] <= orow_d;
      ocol_q[0] <= ocol_d;
      // stages 1..LAT: fixed-latency shift, no stall
      for (int i = 1; i <= LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
        orow_q[i] <= orow_q[i-1];
        ocol_q[i] <= ocol_q[i-1];
      end
    end
  end

  assign out_valid  = vld_q[LAT];
  assign frame_done = vld_q[LAT] & last_q[LAT];
  assign out_row    = orow_q[LAT];
  assign out_col    = ocol_q[LAT];

endmodule

// File: tb/tb_conv_window_ctrl.sv
`timescale 1ns/1ps
module tb_conv_window_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  always #5 clk = ~clk;

  logic       ov0, ov1, ov2, fd0, fd1, fd2;
  logic [2:0] or0, or1, or2, oc0, oc1, oc2;

  // u0: defaults; u1: stride 2; u2: K=1, LAT=1. All share one stimulus stream.
  conv_window_ctrl #(.IMG_W(8), .IMG_H(8), .K(3), .STRIDE(1), .LAT(2)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .out_valid(ov0), .out_row(or0), .out_col(oc0), .frame_done(fd0));
  conv_window_ctrl #(.IMG_W(8), .IMG_H(8), .K(3), .STRIDE(2), .LAT(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .out_valid(ov1), .out_row(or1), .out_col(oc1), .frame_done(fd1));
  conv_window_ctrl #(.IMG_W(8), .IMG_H(8), .K(1), .STRIDE(1), .LAT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .out_valid(ov2), .out_row(or2), .out_col(oc2), .frame_done(fd2));

  localparam int KP [3] = '{3, 3, 1};
  localparam int SP [3] = '{1, 2, 1};
  localparam int LP [3] = '{2, 2, 1};

  typedef struct {
    int due;
    int r;
    int c;
    bit last;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  int tpos = 0;
  int mrow = 0, mcol = 0;
  int pulses [3] = '{0, 0, 0};
  int fdc [3] = '{0, 0, 0};
  bit first_seen = 0;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qfront(input int i);
    case (i)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int i);
    case (i)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic qpush(input int i, input exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Reference model: evaluate the accepted pixel against each configuration.
  task automatic model_accept();
    exp_t e;
    int k, s;
    for (int i = 0; i < 3; i++) begin
      k = KP[i];
      s = SP[i];
      if (mrow >= k - 1 && mcol >= k - 1 &&
          (mrow - k + 1) % s == 0 && (mcol - k + 1) % s == 0) begin
        e.due  = cyc + LP[i];
        e.r    = (mrow - k + 1) / s;
        e.c    = (mcol - k + 1) / s;
        e.last = (e.r == (8 - k) / s) && (e.c == (8 - k) / s);
        qpush(i, e);
      end
    end
    if (mcol == 7) begin
      mcol = 0;
      mrow = (mrow == 7) ? 0 : mrow + 1;
    end else begin
      mcol = mcol + 1;
    end
  endtask

  task automatic check_inst(input int i, input logic ov, input logic [2:0] r,
                            input logic [2:0] c, input logic f);
    exp_t e;
    bit   exp_v;
    exp_v = (qsize(i) > 0) && (qfront(i).due == cyc);
    chk($sformatf("u%0d out_valid c%0d", i, cyc), int'(ov), int'(exp_v));
    if (ov) pulses[i]++;
    if (f) fdc[i]++;
    if (exp_v) begin
      e = qfront(i);
      qpop(i);
      if (ov) begin
        chk($sformatf("u%0d out_row c%0d", i, cyc), int'(r), e.r);
        chk($sformatf("u%0d out_col c%0d", i, cyc), int'(c), e.c);
        chk($sformatf("u%0d frame_done c%0d", i, cyc), int'(f), int'(e.last));
      end
    end else begin
      chk($sformatf("u%0d frame_done idle c%0d", i, cyc), int'(f), 0);
    end
    if (i == 0 && ov && !first_seen) begin
      first_seen = 1;
      chk("u0 first out edge time", tpos, 215);
    end
  endtask

  task automatic check_all();
    check_inst(0, ov0, or0, oc0, fd0);
    check_inst(1, ov1, or1, oc1, fd1);
    check_inst(2, ov2, or2, oc2, fd2);
  endtask

  task automatic step(input bit v);
    in_valid = v;
    @(posedge clk);
    cyc++;
    tpos = int'($time);
    if (rst_n && in_valid) model_accept();
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset pulse of 3 ns placed between edges, mid-frame.
  task automatic rst_pulse();
    in_valid = 1'b1;
    @(posedge clk);
    cyc++;
    tpos = int'($time);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst u0 out_valid", int'(ov0), 0);
    chk("async rst u1 out_valid", int'(ov1), 0);
    chk("async rst u2 out_valid", int'(ov2), 0);
    chk("async rst u0 frame_done", int'(fd0), 0);
    #2 rst_n = 1'b1;
    q0.delete();
    q1.delete();
    q2.delete();
    mrow = 0;
    mcol = 0;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    in_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset out_valid", int'(ov0), 0);
    chk("reset out_row", int'(or0), 0);
    chk("reset out_col", int'(oc0), 0);
    chk("reset frame_done", int'(fd0), 0);
    chk("reset u1 out_valid", int'(ov1), 0);
    chk("reset u2 out_valid", int'(ov2), 0);
    #4 rst_n = 1'b1;

    // two back-to-back frames, in_valid held high
    for (int n = 0; n < 128; n++) step(1'b1);
    for (int n = 0; n < 3; n++) step(1'b0);
    chk("u0 pulses 2 frames", pulses[0], 72);
    chk("u1 pulses 2 frames", pulses[1], 18);
    chk("u2 pulses 2 frames", pulses[2], 128);
    chk("u0 frame_done 2 frames", fdc[0], 2);
    chk("u1 frame_done 2 frames", fdc[1], 2);
    chk("u2 frame_done 2 frames", fdc[2], 2);

    // alternating bubbles: one frame at half rate
    for (int n = 0; n < 128; n++) step(n % 2 == 0);

    // mid-frame asynchronous reset, then restart from pixel (0,0)
    for (int n = 0; n < 30; n++) step(1'b1);
    rst_pulse();
    for (int n = 0; n < 80; n++) step(1'b1);

    // random bubbles
    for (int n = 0; n < 150; n++) step(bit'($urandom_range(0, 1)));

    for (int n = 0; n < 4; n++) step(1'b0);
    chk("u0 pending at end", q0.size(), 0);
    chk("u1 pending at end", q1.size(), 0);
    chk("u2 pending at end", q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
